// File: rtl/activation_pkg.sv
// Shared types and helpers for the streaming activation layer.
package activation_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLIP   = 2'd3
    } act_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } frame_state_t;

    function automatic int unsigned beat_count(input int unsigned c, input int unsigned h,
                                               input int unsigned w, input int unsigned lanes);
        return (c * h * w) / lanes;
    endfunction

endpackage

// File: rtl/act_lane.sv
// Single-element activation function: bypass, ReLU, leaky ReLU or clipped ReLU.
module act_lane
    import activation_pkg::*;
#(
    parameter int unsigned BITWIDTH   = 8,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic signed [BITWIDTH-1:0] i_x,
    input  act_mode_t                  i_mode,
    input  logic signed [BITWIDTH-1:0] i_clip_max,
    output logic signed [BITWIDTH-1:0] o_y
);

    logic signed [BITWIDTH-1:0] w_clip;
    logic                       w_neg;

    always_comb begin
        // A negative ceiling behaves as zero, so clipped output is never negative.
        w_clip = i_clip_max[BITWIDTH-1] ? '0 : i_clip_max;
        w_neg  = i_x[BITWIDTH-1];
        o_y    = i_x;
        case (i_mode)
            ACT_BYPASS: o_y = i_x;
            ACT_RELU:   if (w_neg) o_y = '0;
            ACT_LEAKY:  if (w_neg) o_y = i_x >>> LEAK_SHIFT;
            ACT_CLIP: begin
                if (w_neg)             o_y = '0;
                else if (i_x > w_clip) o_y = w_clip;
            end
            default:    o_y = i_x;
        endcase
    end

endmodule

// File: rtl/activation_stream.sv
// Streaming activation layer: valid/ready beats, per-frame mode, two-stage pipeline.
// Optional zero-element statistics enabled by defining ACTIVATION_STATS_EN.
module activation_stream
    import activation_pkg::*;
#(
    parameter int unsigned BITWIDTH    = 8,
    parameter int unsigned LANES       = 4,
    parameter int unsigned DATACHANNEL = 3,
    parameter int unsigned DATAHEIGHT  = 28,
    parameter int unsigned DATAWIDTH   = 28,
    parameter int unsigned LEAK_SHIFT  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                mode,
    input  logic [BITWIDTH-1:0]       clip_max,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BITWIDTH*LANES-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BITWIDTH*LANES-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic [31:0]               zero_count
);

    localparam int unsigned    BEATS   = beat_count(DATACHANNEL, DATAHEIGHT, DATAWIDTH, LANES);
    localparam int unsigned    CW      = $clog2(BEATS + 1);
    localparam logic [CW-1:0]  BEATS_C = CW'(BEATS);
    localparam int unsigned    DW      = BITWIDTH * LANES;

    frame_state_t        r_state;
    logic [CW-1:0]       r_cnt;
    act_mode_t           r_mode;
    logic [BITWIDTH-1:0] r_clip;
    logic                r_rdy_en;

    logic                r_s1_valid;
    logic                r_s1_last;
    logic [DW-1:0]       r_s1_data;
    act_mode_t           r_s1_mode;
    logic [BITWIDTH-1:0] r_s1_clip;

    logic                r_s2_valid;
    logic                r_s2_last;
    logic [DW-1:0]       r_s2_data;

    logic                w_s2_free;
    logic                w_accept;
    logic                w_first;
    logic                w_last;
    logic [CW-1:0]       w_cnt_next;
    act_mode_t           w_mode;
    logic [BITWIDTH-1:0] w_clip;
    logic [DW-1:0]       w_act;

    assign w_s2_free  = !r_s2_valid || out_ready;
    assign in_ready   = r_rdy_en && (!r_s1_valid || w_s2_free);
    assign w_accept   = in_valid && in_ready;
    assign w_first    = (r_state == ST_IDLE);
    assign w_cnt_next = w_first ? CW'(1) : r_cnt + 1'b1;
    assign w_last     = (w_cnt_next == BEATS_C);
    // The first beat of a frame uses the live controls; later beats use the latched copy.
    assign w_mode     = w_first ? act_mode_t'(mode) : r_mode;
    assign w_clip     = w_first ? clip_max : r_clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= ACT_BYPASS;
            r_clip  <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_mode <= w_mode;
                r_clip <= clip_max;
            end
            if (w_last) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= ST_RUN;
                r_cnt   <= w_cnt_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= ACT_BYPASS;
            r_s1_clip  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_last  <= w_last;
                r_s1_data  <= in_data;
                r_s1_mode  <= w_mode;
                r_s1_clip  <= w_clip;
            end else if (w_s2_free) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_act;
                    r_s2_last <= r_s1_last;
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        act_lane #(
            .BITWIDTH  (BITWIDTH),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) u_lane (
            .i_x       (r_s1_data[k*BITWIDTH +: BITWIDTH]),
            .i_mode    (r_s1_mode),
            .i_clip_max(r_s1_clip),
            .o_y       (w_act[k*BITWIDTH +: BITWIDTH])
        );
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_last  = r_s2_last;
    assign busy      = (r_state == ST_RUN) || r_s1_valid || r_s2_valid;

`ifdef ACTIVATION_STATS_EN
    logic [31:0] r_zero_count;
    logic        r_new_frame;
    logic [31:0] w_zeros;

    always_comb begin
        w_zeros = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (r_s2_data[j*BITWIDTH +: BITWIDTH] == '0) w_zeros = w_zeros + 32'd1;
        end
    end

    // The total holds after the last beat and restarts on the next frame's first transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_count <= '0;
            r_new_frame  <= 1'b1;
        end else if (r_s2_valid && out_ready) begin
            r_zero_count <= r_new_frame ? w_zeros : r_zero_count + w_zeros;
            r_new_frame  <= r_s2_last;
        end
    end

    assign zero_count = r_zero_count;
`else
    assign zero_count = '0;
`endif

endmodule

// File: doc/activation_stream.md
# activation_stream

Streaming, parametrised successor to the flat combinational activation layer. Accepts feature-map elements as multi-lane beats over a valid/ready handshake, applies one of four run-time-selectable nonlinearities per frame, and emits results through a two-stage pipeline with a frame-end marker. Sits between the convolution accumulator output and the pooling stage of the conv net datapath.

## Interface
- BITWIDTH, 8, signed two's-complement element width
- LANES, 4, elements per beat
- DATACHANNEL, 3, channels per frame
- DATAHEIGHT, 28, rows per frame
- DATAWIDTH, 28, columns per frame; DATACHANNEL*DATAHEIGHT*DATAWIDTH must be a multiple of LANES
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  activation select, sampled on first accepted beat of a frame
- clip_max  in  BITWIDTH  signed upper bound for clipped mode, sampled with mode
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  BITWIDTH*LANES  lane k at [k*BITWIDTH +: BITWIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  BITWIDTH*LANES  results, same lane packing
- out_last  out  1  high on final beat of frame
- busy  out  1  frame in progress or pipeline non-empty
- zero_count  out  32  zero-valued output elements in current frame (see Configuration)

## Operation
- Modes: 0 bypass (y=x); 1 ReLU (y = x<0 ? 0 : x); 2 leaky (y = x<0 ? x>>>LEAK_SHIFT : x, arithmetic shift, truncation toward -inf); 3 clipped (y = min(max(x,0), clip_max); clip_max<0 treated as 0).
- No widening: output width equals BITWIDTH; no operation can overflow.
- Frame FSM: IDLE, RUN. IDLE -> RUN on first accepted beat (latch mode, clip_max; beat counter = 1). RUN -> IDLE when accepted beat count reaches BEATS = C*H*W/LANES; counter returns to 0. Frame of exactly one beat goes IDLE -> IDLE with that beat marked last.
- mode/clip_max changes during RUN are ignored until next frame.
- Beat counter width $clog2(BEATS+1); wraps to 0 only at frame end.
- last flag travels with data through both stages.
- Reset values: in_ready 0 during reset then 1; out_valid 0; out_data 0; out_last 0; busy 0; zero_count 0; FSM IDLE; counter 0; latched mode 0.
- Reset asserted mid-frame discards all in-flight beats; next accepted beat starts a new frame.

## Timing
- Stage 1 registers input and latched mode; stage 2 registers activation result. Latency 2 cycles from input accept to out_valid with out_ready held high.
- Throughput 1 beat/cycle sustained.
- Backpressure: each stage advances when its downstream slot is empty or being consumed; in_ready = !s1_valid || (!s2_valid || out_ready). No combinational path from in_valid to out_valid; out_ready -> in_ready is the only combinational path.
- out_data/out_last stable while out_valid && !out_ready.
- Back-to-back frames: first beat of frame N+1 accepted the cycle after last beat of frame N, latching new mode; no bubble.
- busy = (state==RUN) || s1_valid || s2_valid.

## Configuration
- ACTIVATION_STATS_EN defined: zero_count increments by the number of zero lanes in each output beat transferred (out_valid && out_ready); holds its final value after out_last transfer; cleared on the transfer of the next frame's first output beat (value = that beat's zeros).
- Undefined: port present, tied to 0; no counter logic.

## Structure
- Package activation_pkg: typedef enum logic [1:0] act_mode_t {ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLIP}; beat-count function.
- Sub-module act_lane: combinational single-element function (x, mode, clip_max -> y), instantiated LANES times in a generate loop; pipeline, FSM, counters in activation_stream.

## Test plan
- Mode 1, LANES=4, beat {-5,0,7,-128} -> {0,0,7,0} two cycles later, out_last on beat 588 of 588.
- Mode 2, LEAK_SHIFT=3: {-8,-1,-128,100} -> {-1,-1,-16,100}.
- Mode 3, clip_max=6: {-3,4,6,90} -> {0,4,6,6}; clip_max=-2: {5} lane -> 0.
- Random out_ready stalls (50%) across two frames, mode changed mid-frame 1 -> no lost/duplicated beats, frame 1 keeps original mode, frame 2 uses new mode.
- rst_n pulsed low mid-frame with s1/s2 full -> out_valid 0 immediately, busy 0; fresh frame completes with correct out_last.
- ACTIVATION_STATS_EN, mode 1, frame with 100 negative and 20 zero inputs -> zero_count 120 after out_last.
